// File: rtl/fifo_drain_checker_if.sv
// FIFO read-port bundle between the drain checker (master) and the FIFO (slave).
interface fifo_drain_checker_if;
  logic [3:0] fifo_words;
  logic [7:0] fifo_data;
  logic       rd_en;

  modport master (output rd_en, input fifo_words, input fifo_data);
  modport slave  (input rd_en, output fifo_words, output fifo_data);
endinterface

// File: rtl/fifo_drain_checker.sv
// Drains the test FIFO with start/stop level hysteresis and checks every word
// read against a fixed pattern, keeping saturating good/bad counts and a sticky error.

module fdc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module fifo_drain_checker #(
  parameter logic [7:0] EXPECTED    = 8'hAA,
  parameter int         START_LEVEL = 3,
  parameter int         STOP_LEVEL  = 0,
  parameter int         CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  fifo_drain_checker_if.master   fifo,
  output logic                   data_valid,
  output logic [7:0]             last_data,
  output logic [CNT_W-1:0]       good_cnt,
  output logic [CNT_W-1:0]       bad_cnt,
  output logic                   err
);
  localparam logic [3:0] START_L = 4'(START_LEVEL);
  localparam logic [3:0] STOP_L  = 4'(STOP_LEVEL);

  // One-hot so that a corrupted register has a distinct encoding to recover from.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    READ = 2'b10
  } state_t;

  state_t state, state_nx;
  logic   rd_en_c;
  logic   rd_d;
  logic   match;
  logic   good_inc, bad_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en_c  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && fifo.fifo_words >= START_L) state_nx = READ;
      end
      READ: begin
        // The read strobe depends on the live level so it falls in the same
        // cycle the FIFO reaches the stop level; no underflow is possible.
        rd_en_c = enable && (fifo.fifo_words > STOP_L);
        if (!enable || fifo.fifo_words <= STOP_L) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fifo.rd_en = rd_en_c;

  // Check stage runs off the delayed strobe, independent of state, so the
  // response to a read issued in the last READ cycle is still checked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_d <= 1'b0;
    else     rd_d <= rd_en_c;
  end

  assign data_valid = rd_d;
  assign match      = (fifo.fifo_data == EXPECTED);
  assign good_inc   = rd_d && match;
  assign bad_inc    = rd_d && !match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data <= '0;
      err       <= 1'b0;
    end else if (rd_d) begin
      last_data <= fifo.fifo_data;
      if (!match) err <= 1'b1;
    end
  end

  fdc_sat_cnt #(.W(CNT_W)) u_good (.clk(clk), .rst(rst), .inc(good_inc), .cnt(good_cnt));
  fdc_sat_cnt #(.W(CNT_W)) u_bad  (.clk(clk), .rst(rst), .inc(bad_inc),  .cnt(bad_cnt));
endmodule
